// File: rtl/c4_move_controller.sv
// ============================================================================
// c4_move_controller
// ----------------------------------------------------------------------------
// Sequences one Connect-4 move. It takes a column request, checks that the
// column exists and is not full, and writes the piece into the board store.
// It then runs the external win checker. When the checker finishes, the
// controller does one of two things:
//   - it hands the turn over with a single turn_toggle pulse, or
//   - it ends the game because of a win or a draw.
// This block is the only driver of the turn tracker's enable.
//
// Optional feature macro: C4_DROP_ANIM_EN
//   When defined, a DROP state sits between VALIDATE and WRITE. During DROP
//   the block drives a falling-piece marker (o_anim_valid / o_anim_row). The
//   marker starts at the top row and steps down one row every DROP_CYCLES
//   clocks until it reaches the landing row.
//   When undefined, DROP does not exist and the marker outputs are tied to 0.
//
// Parameters:
//   COLS        number of board columns (1..8)
//   ROWS        number of board rows    (1..7)
//   DROP_CYCLES clocks per row step of the drop animation
//
// Ports:
//   clk            system clock
//   reset          synchronous active-high reset, doubles as new-game
//   i_move_req     one-cycle request to play i_move_col (seen only in IDLE)
//   i_move_col     requested column, 0 = leftmost
//   i_player       current colour from the turn tracker
//   o_wr_en        board write strobe
//   o_wr_row       board write row, 0 = bottom (held until the next write)
//   o_wr_col       board write column (held until the next write)
//   o_wr_colour    colour written (copy of i_player)
//   o_chk_start    one-cycle start pulse for the win checker
//   i_chk_done     win checker finished (seen only in CHK_WAIT)
//   i_chk_win      valid with i_chk_done, 1 = last move made four in a row
//   o_turn_toggle  enable pulse to the turn tracker
//   o_move_ack     move accepted and completed, game continues
//   o_move_reject  move refused (bad column, full column or game over)
//   o_busy         controller is not in IDLE
//   o_game_over    sticky until reset
//   o_winner       colour of the winner, 00 if none or draw
//   o_draw         sticky, board full with no winner
//   o_anim_valid   falling-piece marker valid
//   o_anim_row     falling-piece marker row
// ============================================================================
module c4_move_controller #(
    parameter int COLS        = 7,
    parameter int ROWS        = 6,
    parameter int DROP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_move_req,
    input  logic [2:0] i_move_col,
    input  logic [1:0] i_player,
    output logic       o_wr_en,
    output logic [2:0] o_wr_row,
    output logic [2:0] o_wr_col,
    output logic [1:0] o_wr_colour,
    output logic       o_chk_start,
    input  logic       i_chk_done,
    input  logic       i_chk_win,
    output logic       o_turn_toggle,
    output logic       o_move_ack,
    output logic       o_move_reject,
    output logic       o_busy,
    output logic       o_game_over,
    output logic [1:0] o_winner,
    output logic       o_draw,
    output logic       o_anim_valid,
    output logic [2:0] o_anim_row
);

    // Total number of cells on the board. The board is full when the piece
    // counter reaches this value.
    localparam int         CELLS    = ROWS * COLS;
    localparam logic [5:0] CELLS_W  = 6'(CELLS);
    localparam logic [2:0] ROWS_W   = 3'(ROWS);
    localparam logic [3:0] COLS_W   = 4'(COLS);

`ifdef C4_DROP_ANIM_EN
    localparam int         CW       = (DROP_CYCLES > 1) ? $clog2(DROP_CYCLES) : 1;
    localparam logic [CW-1:0] DROP_LAST = CW'(DROP_CYCLES - 1);
`endif

    typedef enum logic [3:0] {
        IDLE,
        VALIDATE,
`ifdef C4_DROP_ANIM_EN
        DROP,
`endif
        WRITE,
        CHK_START,
        CHK_WAIT,
        TOGGLE,
        REJECT,
        OVER
    } state_t;

    state_t     r_state;
    logic [2:0] r_col;
    logic [5:0] r_pieceCnt;

    // The height table always has eight entries, so any 3-bit column index
    // is legal. Entries at COLS and above are never written.
    logic [2:0] r_height [0:7];

`ifdef C4_DROP_ANIM_EN
    logic [CW-1:0] r_dropCnt;
`endif

    logic [2:0] w_curHeight;
    logic       w_colInRange;
    logic       w_colFull;

    // Height of the latched column and the two ways a move can be refused.
    // The column is zero-extended before the compare so that COLS = 8 still
    // works with a 3-bit column.
    always_comb begin
        w_curHeight  = r_height[r_col];
        w_colInRange = ({1'b0, r_col} < COLS_W);
        w_colFull    = (w_curHeight == ROWS_W);
    end

    // Main move sequencer. The state register and all outputs are updated
    // together, so each output is already valid in the cycle its state
    // becomes current.
    //
    // Pulse outputs default low every cycle and are raised only on entry to
    // the state that owns them.
    //
    // wr_row and wr_col are left alone outside WRITE. The win checker keeps
    // reading them after the write strobe has gone.
    //
    // Reset clears the board bookkeeping from any state. This includes an
    // animation in progress: the piece is dropped with nothing written.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_col         <= '0;
            r_pieceCnt    <= '0;
            o_wr_en       <= 1'b0;
            o_wr_row      <= '0;
            o_wr_col      <= '0;
            o_wr_colour   <= '0;
            o_chk_start   <= 1'b0;
            o_turn_toggle <= 1'b0;
            o_move_ack    <= 1'b0;
            o_move_reject <= 1'b0;
            o_busy        <= 1'b0;
            o_game_over   <= 1'b0;
            o_winner      <= '0;
            o_draw        <= 1'b0;
            for (int c = 0; c < 8; c++) begin
                r_height[c] <= '0;
            end
`ifdef C4_DROP_ANIM_EN
            o_anim_valid  <= 1'b0;
            o_anim_row    <= '0;
            r_dropCnt     <= '0;
`endif
        end else begin
            o_wr_en       <= 1'b0;
            o_chk_start   <= 1'b0;
            o_turn_toggle <= 1'b0;
            o_move_ack    <= 1'b0;
            o_move_reject <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (i_move_req) begin
                        r_col   <= i_move_col;
                        r_state <= VALIDATE;
                        o_busy  <= 1'b1;
                    end
                end

                VALIDATE: begin
                    if (!w_colInRange || w_colFull) begin
                        o_move_reject <= 1'b1;
                        r_state       <= REJECT;
                    end else begin
`ifdef C4_DROP_ANIM_EN
                        o_anim_valid <= 1'b1;
                        o_anim_row   <= ROWS_W - 3'd1;
                        r_dropCnt    <= '0;
                        r_state      <= DROP;
`else
                        o_wr_en      <= 1'b1;
                        o_wr_row     <= w_curHeight;
                        o_wr_col     <= r_col;
                        o_wr_colour  <= i_player;
                        r_state      <= WRITE;
`endif
                    end
                end

`ifdef C4_DROP_ANIM_EN
                // The marker stays on each row for DROP_CYCLES clocks. Once
                // it has stayed that long on the landing row, the real write
                // follows in the next cycle.
                DROP: begin
                    if (r_dropCnt == DROP_LAST) begin
                        r_dropCnt <= '0;
                        if (o_anim_row == w_curHeight) begin
                            o_anim_valid <= 1'b0;
                            o_anim_row   <= '0;
                            o_wr_en      <= 1'b1;
                            o_wr_row     <= w_curHeight;
                            o_wr_col     <= r_col;
                            o_wr_colour  <= i_player;
                            r_state      <= WRITE;
                        end else begin
                            o_anim_row <= o_anim_row - 3'd1;
                        end
                    end else begin
                        r_dropCnt <= r_dropCnt + CW'(1);
                    end
                end
`endif

                WRITE: begin
                    r_height[r_col] <= w_curHeight + 3'd1;
                    r_pieceCnt      <= r_pieceCnt + 6'd1;
                    o_chk_start     <= 1'b1;
                    r_state         <= CHK_START;
                end

                CHK_START: begin
                    r_state <= CHK_WAIT;
                end

                // The piece count already includes the piece just placed.
                // A win is tested first: a move that completes four in a
                // row and also fills the board is a win, not a draw.
                CHK_WAIT: begin
                    if (i_chk_done) begin
                        if (i_chk_win) begin
                            o_winner    <= i_player;
                            o_game_over <= 1'b1;
                            r_state     <= OVER;
                        end else if (r_pieceCnt == CELLS_W) begin
                            o_draw      <= 1'b1;
                            o_game_over <= 1'b1;
                            r_state     <= OVER;
                        end else begin
                            o_turn_toggle <= 1'b1;
                            o_move_ack    <= 1'b1;
                            r_state       <= TOGGLE;
                        end
                    end
                end

                TOGGLE: begin
                    o_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                REJECT: begin
                    o_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                // The game has ended. Any further request is refused, and
                // only reset leaves this state.
                OVER: begin
                    if (i_move_req) begin
                        o_move_reject <= 1'b1;
                    end
                end

                default: begin
                    o_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifndef C4_DROP_ANIM_EN
    // Without the animation feature there is no falling-piece marker.
    assign o_anim_valid = 1'b0;
    assign o_anim_row   = 3'd0;
`endif

endmodule

// File: tb/tb_c4_move_controller.sv
// ============================================================================
// tb_c4_move_controller
// ----------------------------------------------------------------------------
// Directed bench for the Connect-4 move controller. Each scenario task drives
// its own stimulus and compares the outputs with hand-computed values.
// Outputs are sampled 1 time unit after the rising clock edge.
// ============================================================================
module tb_c4_move_controller;

    localparam int COLS        = 7;
    localparam int ROWS        = 6;
    localparam int DROP_CYCLES = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       moveReq;
    logic [2:0] moveCol;
    logic [1:0] player;
    logic       chkDone;
    logic       chkWin;

    logic       wrEn;
    logic [2:0] wrRow;
    logic [2:0] wrCol;
    logic [1:0] wrColour;
    logic       chkStart;
    logic       turnToggle;
    logic       moveAck;
    logic       moveReject;
    logic       busy;
    logic       gameOver;
    logic [1:0] winner;
    logic       draw;
    logic       animValid;
    logic [2:0] animRow;

    int checks = 0;
    int errors = 0;

    c4_move_controller #(
        .COLS        (COLS),
        .ROWS        (ROWS),
        .DROP_CYCLES (DROP_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_move_req    (moveReq),
        .i_move_col    (moveCol),
        .i_player      (player),
        .o_wr_en       (wrEn),
        .o_wr_row      (wrRow),
        .o_wr_col      (wrCol),
        .o_wr_colour   (wrColour),
        .o_chk_start   (chkStart),
        .i_chk_done    (chkDone),
        .i_chk_win     (chkWin),
        .o_turn_toggle (turnToggle),
        .o_move_ack    (moveAck),
        .o_move_reject (moveReject),
        .o_busy        (busy),
        .o_game_over   (gameOver),
        .o_winner      (winner),
        .o_draw        (draw),
        .o_anim_valid  (animValid),
        .o_anim_row    (animRow)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Watchdog so that a stuck run still terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Every DUT output packed into one word, used to compare against zero.
    function automatic logic [21:0] allOuts();
        return {wrEn, wrRow, wrCol, wrColour, chkStart, turnToggle, moveAck,
                moveReject, busy, gameOver, winner, draw, animValid, animRow};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset   = 1'b1;
        moveReq = 1'b0;
        tick();
        tick();
        reset   = 1'b0;
    endtask

    // Plays one move with the checker answering at once. It then waits, for
    // a bounded number of cycles, until the controller is idle again or the
    // game is over. It records what happened and makes no judgement.
    task automatic doMove(input logic [2:0] col, input logic [1:0] ply,
                          input logic win,
                          output logic sawWr, output logic sawAck,
                          output logic sawRej, output logic sawTog,
                          output logic timedOut, output logic [2:0] gotRow);
        logic done;
        sawWr = 0; sawAck = 0; sawRej = 0; sawTog = 0; done = 0; gotRow = '0;
        moveCol = col; player = ply; chkDone = 1'b1; chkWin = win;
        moveReq = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            moveReq = 1'b0;
            if (wrEn)       begin sawWr = 1; gotRow = wrRow; end
            if (moveAck)    sawAck = 1;
            if (moveReject) sawRej = 1;
            if (turnToggle) sawTog = 1;
            if (!busy || (gameOver && i >= 2)) begin
                done = 1;
                break;
            end
        end
        timedOut = !done;
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if (allOuts() !== 22'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 000000", allOuts());
        end
        tick(); tick(); tick();
        checks++;
        if (busy !== 1'b0 || allOuts() !== 22'd0) begin
            errors++;
            $display("[TB] FAIL idle_quiet: got %h expected 000000", allOuts());
        end
    endtask

    task automatic test_latency();
        int wrCyc;
`ifdef C4_DROP_ANIM_EN
        wrCyc = 2 + ROWS * DROP_CYCLES;
`else
        wrCyc = 2;
`endif
        doReset();
        chkDone = 1'b1; chkWin = 1'b0; moveCol = 3'd3; player = 2'b01;
        moveReq = 1'b1;
        for (int c = 1; c <= wrCyc + 4; c++) begin
            tick();
            moveReq = 1'b0;
            if (c == 1) begin
                checks++;
                if (busy !== 1'b1 || wrEn !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL lat_busy_c1: got busy=%b wr_en=%b expected busy=1 wr_en=0", busy, wrEn);
                end
            end
            if (c == wrCyc) begin
                checks++;
                if (wrEn !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL lat_wr_en: got %b expected 1", wrEn);
                end
                checks++;
                if (wrRow !== 3'd0 || wrCol !== 3'd3 || wrColour !== 2'b01) begin
                    errors++;
                    $display("[TB] FAIL lat_wr_data: got row=%0d col=%0d colour=%b expected row=0 col=3 colour=01", wrRow, wrCol, wrColour);
                end
            end
            if (c == wrCyc + 1) begin
                checks++;
                if (chkStart !== 1'b1 || wrEn !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL lat_chk_start: got chk_start=%b wr_en=%b expected 1/0", chkStart, wrEn);
                end
            end
            if (c == wrCyc + 2) begin
                checks++;
                if (moveAck !== 1'b0 || chkStart !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL lat_early_ack: got ack=%b chk_start=%b expected 0/0", moveAck, chkStart);
                end
            end
            if (c == wrCyc + 3) begin
                checks++;
                if (moveAck !== 1'b1 || turnToggle !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL lat_ack_toggle: got ack=%b toggle=%b expected 1/1", moveAck, turnToggle);
                end
            end
            if (c == wrCyc + 4) begin
                checks++;
                if (busy !== 1'b0 || moveAck !== 1'b0 || turnToggle !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL lat_idle: got busy=%b ack=%b toggle=%b expected 0/0/0", busy, moveAck, turnToggle);
                end
                checks++;
                if (wrRow !== 3'd0 || wrCol !== 3'd3) begin
                    errors++;
                    $display("[TB] FAIL lat_wr_hold: got row=%0d col=%0d expected row=0 col=3", wrRow, wrCol);
                end
            end
        end
    endtask

    task automatic test_full_column();
        logic sWr, sAck, sRej, sTog, tOut;
        logic [2:0] gRow;
        doReset();
        for (int i = 0; i < ROWS; i++) begin
            doMove(3'd0, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, sWr, sAck, sRej, sTog, tOut, gRow);
            checks++;
            if (tOut || !sWr || !sAck || sRej || gRow !== 3'(i)) begin
                errors++;
                $display("[TB] FAIL fill_col0_move%0d: got row=%0d wr=%b ack=%b rej=%b timeout=%b expected row=%0d wr=1 ack=1 rej=0 timeout=0", i, gRow, sWr, sAck, sRej, tOut, i);
            end
        end
        doMove(3'd0, 2'b01, 1'b0, sWr, sAck, sRej, sTog, tOut, gRow);
        checks++;
        if (tOut || sWr || sAck || !sRej || sTog) begin
            errors++;
            $display("[TB] FAIL full_col_reject: got wr=%b ack=%b rej=%b toggle=%b timeout=%b expected 0/0/1/0/0", sWr, sAck, sRej, sTog, tOut);
        end
        doMove(3'd7, 2'b01, 1'b0, sWr, sAck, sRej, sTog, tOut, gRow);
        checks++;
        if (tOut || sWr || sAck || !sRej) begin
            errors++;
            $display("[TB] FAIL bad_col_reject: got wr=%b ack=%b rej=%b timeout=%b expected 0/0/1/0", sWr, sAck, sRej, tOut);
        end
        doMove(3'd0, 2'b10, 1'b0, sWr, sAck, sRej, sTog, tOut, gRow);
        checks++;
        if (tOut || sWr || !sRej) begin
            errors++;
            $display("[TB] FAIL full_col_unchanged: got wr=%b rej=%b timeout=%b expected 0/1/0", sWr, sRej, tOut);
        end
        doMove(3'd1, 2'b10, 1'b0, sWr, sAck, sRej, sTog, tOut, gRow);
        checks++;
        if (tOut || !sWr || !sAck || gRow !== 3'd0 || wrCol !== 3'd1) begin
            errors++;
            $display("[TB] FAIL after_reject_move: got row=%0d col=%0d ack=%b timeout=%b expected row=0 col=1 ack=1 timeout=0", gRow, wrCol, sAck, tOut);
        end
    endtask

    task automatic test_win();
        logic sWr, sAck, sRej, sTog, tOut;
        logic [2:0] gRow;
        doReset();
        doMove(3'd4, 2'b10, 1'b1, sWr, sAck, sRej, sTog, tOut, gRow);
        checks++;
        if (tOut || gameOver !== 1'b1 || winner !== 2'b10 || draw !== 1'b0) begin
            errors++;
            $display("[TB] FAIL win_state: got over=%b winner=%b draw=%b timeout=%b expected 1/10/0/0", gameOver, winner, draw, tOut);
        end
        checks++;
        if (sTog || sAck) begin
            errors++;
            $display("[TB] FAIL win_no_toggle: got toggle=%b ack=%b expected 0/0", sTog, sAck);
        end
        tick(); tick(); tick();
        checks++;
        if (gameOver !== 1'b1 || busy !== 1'b1 || winner !== 2'b10) begin
            errors++;
            $display("[TB] FAIL win_sticky: got over=%b busy=%b winner=%b expected 1/1/10", gameOver, busy, winner);
        end
        doMove(3'd5, 2'b01, 1'b0, sWr, sAck, sRej, sTog, tOut, gRow);
        checks++;
        if (tOut || !sRej || sWr || sAck) begin
            errors++;
            $display("[TB] FAIL over_reject: got rej=%b wr=%b ack=%b timeout=%b expected 1/0/0/0", sRej, sWr, sAck, tOut);
        end
        doReset();
        checks++;
        if (gameOver !== 1'b0 || winner !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL win_reset_clear: got over=%b winner=%b busy=%b expected 0/00/0", gameOver, winner, busy);
        end
        doMove(3'd4, 2'b01, 1'b0, sWr, sAck, sRej, sTog, tOut, gRow);
        checks++;
        if (tOut || !sWr || gRow !== 3'd0 || !sAck) begin
            errors++;
            $display("[TB] FAIL win_reset_height: got row=%0d wr=%b ack=%b timeout=%b expected row=0 wr=1 ack=1 timeout=0", gRow, sWr, sAck, tOut);
        end
    endtask

    task automatic test_draw();
        logic sWr, sAck, sRej, sTog, tOut;
        logic [2:0] gRow;
        int n;
        n = 0;
        doReset();
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                n++;
                doMove(3'(c), (n % 2 == 1) ? 2'b01 : 2'b10, 1'b0, sWr, sAck, sRej, sTog, tOut, gRow);
                if (n < ROWS * COLS) begin
                    checks++;
                    if (tOut || !sAck || !sTog || gameOver || gRow !== 3'(r)) begin
                        errors++;
                        $display("[TB] FAIL draw_fill_move%0d: got row=%0d ack=%b toggle=%b over=%b timeout=%b expected row=%0d 1/1/0/0", n, gRow, sAck, sTog, gameOver, tOut, r);
                    end
                end
            end
        end
        checks++;
        if (tOut || draw !== 1'b1 || gameOver !== 1'b1 || winner !== 2'b00) begin
            errors++;
            $display("[TB] FAIL draw_state: got draw=%b over=%b winner=%b timeout=%b expected 1/1/00/0", draw, gameOver, winner, tOut);
        end
        checks++;
        if (sAck || sTog || !sWr || gRow !== 3'd5) begin
            errors++;
            $display("[TB] FAIL draw_last_move: got ack=%b toggle=%b wr=%b row=%0d expected 0/0/1/5", sAck, sTog, sWr, gRow);
        end
        doMove(3'd3, 2'b10, 1'b0, sWr, sAck, sRej, sTog, tOut, gRow);
        checks++;
        if (tOut || !sRej || sWr) begin
            errors++;
            $display("[TB] FAIL draw_over_reject: got rej=%b wr=%b timeout=%b expected 1/0/0", sRej, sWr, tOut);
        end
    endtask

    task automatic test_chk_wait();
        logic sWr, sAck, sRej, sTog, tOut;
        logic [2:0] gRow;
        int bad;
        doReset();
        chkDone = 1'b0; chkWin = 1'b0; moveCol = 3'd2; player = 2'b01;
        moveReq = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            moveReq = 1'b0;
        end
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            moveReq = 1'b0;
            if (k == 8) begin
                moveCol = 3'd5;
                moveReq = 1'b1;
            end
            if (busy !== 1'b1 || wrEn !== 1'b0 || moveAck !== 1'b0 || moveReject !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL wait_hold: got %0d bad cycles expected 0", bad);
        end
        chkDone = 1'b1;
        tick();
        checks++;
        if (moveAck !== 1'b1 || turnToggle !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wait_release: got ack=%b toggle=%b expected 1/1", moveAck, turnToggle);
        end
        bad = 0;
        tick();
        for (int k = 0; k < 5; k++) begin
            if (busy !== 1'b0 || wrEn !== 1'b0)
                bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL wait_req_dropped: got %0d busy cycles expected 0", bad);
        end
        chkDone = 1'b0; moveCol = 3'd6; player = 2'b10;
        moveReq = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            moveReq = 1'b0;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wait2_busy: got %b expected 1", busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (allOuts() !== 22'd0) begin
            errors++;
            $display("[TB] FAIL wait_reset_outputs: got %h expected 000000", allOuts());
        end
        doMove(3'd2, 2'b01, 1'b0, sWr, sAck, sRej, sTog, tOut, gRow);
        checks++;
        if (tOut || !sWr || gRow !== 3'd0 || !sAck) begin
            errors++;
            $display("[TB] FAIL wait_reset_height: got row=%0d wr=%b ack=%b timeout=%b expected 0/1/1/0", gRow, sWr, sAck, tOut);
        end
    endtask

    task automatic test_back_to_back();
        logic sWr, sAck, sRej, sTog, tOut;
        logic [2:0] gRow;
        logic [2:0] rows [3];
        logic [1:0] cols [3];
        cols[0] = 2'b01; cols[1] = 2'b10; cols[2] = 2'b11;
        doReset();
        for (int m = 0; m < 3; m++) begin
            doMove(3'd6, cols[m], 1'b0, sWr, sAck, sRej, sTog, tOut, gRow);
            rows[m] = tOut ? 3'd7 : gRow;
        end
        checks++;
        if (rows[0] !== 3'd0 || rows[1] !== 3'd1 || rows[2] !== 3'd2) begin
            errors++;
            $display("[TB] FAIL b2b_rows: got %0d,%0d,%0d expected 0,1,2", rows[0], rows[1], rows[2]);
        end
        checks++;
        if (wrColour !== 2'b11 || wrCol !== 3'd6 || wrRow !== 3'd2 || winner !== 2'b00) begin
            errors++;
            $display("[TB] FAIL b2b_raw_colour: got colour=%b col=%0d row=%0d winner=%b expected 11/6/2/00", wrColour, wrCol, wrRow, winner);
        end
    endtask

`ifdef C4_DROP_ANIM_EN
    task automatic test_anim();
        logic sWr, sAck, sRej, sTog, tOut;
        logic [2:0] gRow;
        int bad;
        logic done;
        doReset();
        doMove(3'd2, 2'b01, 1'b0, sWr, sAck, sRej, sTog, tOut, gRow);
        moveCol = 3'd2; player = 2'b10; chkDone = 1'b1; chkWin = 1'b0;
        moveReq = 1'b1;
        bad = 0;
        done = 0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            moveReq = 1'b0;
            if (c >= 2 && c <= 21) begin
                if (animValid !== 1'b1 || animRow !== 3'(5 - (c - 2) / DROP_CYCLES) || wrEn !== 1'b0)
                    bad++;
            end
            if (c == 22) begin
                checks++;
                if (wrEn !== 1'b1 || wrRow !== 3'd1 || animValid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL anim_write: got wr_en=%b row=%0d anim_valid=%b expected 1/1/0", wrEn, wrRow, animValid);
                end
            end
            if (c > 22 && !busy) begin
                done = 1;
                break;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL anim_steps: got %0d bad cycles expected 0", bad);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL anim_finish: got busy=%b expected 0 within bound", busy);
        end
    endtask
`else
    task automatic test_anim();
        int bad;
        logic done;
        doReset();
        moveCol = 3'd2; player = 2'b10; chkDone = 1'b1; chkWin = 1'b0;
        moveReq = 1'b1;
        bad = 0;
        done = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            moveReq = 1'b0;
            if (animValid !== 1'b0 || animRow !== 3'd0)
                bad++;
            if (c > 1 && !busy) begin
                done = 1;
                break;
            end
        end
        checks++;
        if (bad != 0 || !done) begin
            errors++;
            $display("[TB] FAIL anim_tied_off: got %0d bad cycles done=%b expected 0/1", bad, done);
        end
    endtask
`endif

    initial begin
        reset   = 1'b1;
        moveReq = 1'b0;
        moveCol = 3'd0;
        player  = 2'b01;
        chkDone = 1'b0;
        chkWin  = 1'b0;
        test_reset();
        test_latency();
        test_full_column();
        test_win();
        test_draw();
        test_chk_wait();
        test_back_to_back();
        test_anim();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/c4_move_controller.md
Name: c4_move_controller

Overview:
- Sequences one Connect-4 move from a column request to the turn hand-off.
- Steps: validates the column, writes the piece to the board store, runs the external win checker, then pulses the turn tracker's enable, or ends the game.
- Sits between the player input/debounce logic, the board memory, the win-check unit and the turn tracker. It is the only block that drives the turn tracker's enable.

Parameters:
- COLS, 7, number of board columns (max 8).
- ROWS, 6, number of board rows (max 7).
- DROP_CYCLES, 4, clocks per row step of the falling-piece animation (used only with C4_DROP_ANIM_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; also used as new-game.
- move_req  in  1  one-cycle request to play move_col; sampled only in IDLE.
- move_col  in  3  requested column, 0 = leftmost.
- player  in  2  current colour from turn tracker, 01 or 10.
- wr_en  out  1  board write strobe.
- wr_row  out  3  board write row, 0 = bottom.
- wr_col  out  3  board write column.
- wr_colour  out  2  colour written (= player).
- chk_start  out  1  one-cycle start to win checker; checker looks at (wr_row, wr_col).
- chk_done  in  1  win checker finished; sampled only in CHK_WAIT.
- chk_win  in  1  valid with chk_done; 1 = last move made four in a row.
- turn_toggle  out  1  enable pulse to the turn tracker.
- move_ack  out  1  move accepted and completed, game continues.
- move_reject  out  1  move refused: bad column, full column, or game over.
- busy  out  1  state != IDLE.
- game_over  out  1  sticky until reset.
- winner  out  2  colour of winner; 00 if none or draw.
- draw  out  1  sticky; board full with no winner.
- anim_valid  out  1  falling-piece marker valid.
- anim_row  out  3  falling-piece row.

Behaviour:
- All outputs are registered / Moore-decoded from state.
- Reset value of every output is 0; state resets to IDLE.
- Reset also clears all column heights and the piece count, whatever the current state.
- Internal state: height[c] (0..ROWS) per column; piece_cnt (0..ROWS*COLS).
- States: IDLE, VALIDATE, DROP, WRITE, CHK_START, CHK_WAIT, TOGGLE, REJECT, OVER.
- IDLE: on move_req=1, latch move_col and go to VALIDATE; else stay.
- VALIDATE: if col >= COLS or height[col] == ROWS, go to REJECT; else go to DROP (with animation) or WRITE (without).
- REJECT: move_reject=1 for one cycle, then IDLE. No state is changed.
- WRITE, one cycle:
  - wr_en=1, wr_row=height[col], wr_col=col, wr_colour=player.
  - height[col] and piece_cnt increment at the end of the cycle.
  - wr_row/wr_col hold their values until the next WRITE, so the checker can use them.
- CHK_START: chk_start=1 for one cycle, then CHK_WAIT.
- CHK_WAIT: wait indefinitely for chk_done. Exit on chk_done=1:
  - chk_win=1: winner=player, game_over=1, go to OVER.
  - else piece_cnt == ROWS*COLS: draw=1, game_over=1, go to OVER.
  - else: go to TOGGLE.
- TOGGLE: turn_toggle=1 and move_ack=1 together for one cycle, then IDLE.
- No turn_toggle on a winning or drawing move; player stays the winner's colour.
- OVER: move_req=1 gives move_reject=1 on the following cycle; stay in OVER until reset.
- Latency, valid non-terminal move with chk_done arriving in the first CHK_WAIT cycle:
  - req at cycle 0; VALIDATE 1, WRITE 2, CHK_START 3, CHK_WAIT 4, TOGGLE 5.
  - move_ack/turn_toggle high in cycle 5.
- move_req while busy: ignored, not queued.
- chk_done outside CHK_WAIT: ignored.
- A player value other than 01/10 is written as-is; no checking is done.

Optional Feature:
- Macro C4_DROP_ANIM_EN.
- Defined:
  - VALIDATE goes to DROP.
  - DROP asserts anim_valid, with anim_row starting at ROWS-1.
  - anim_row decrements every DROP_CYCLES clocks until it equals height[col]; after that cell's DROP_CYCLES, go to WRITE.
  - DROP duration = (ROWS - height[col]) * DROP_CYCLES cycles.
  - Reset during DROP aborts with nothing written.
- Not defined: DROP state does not exist; VALIDATE goes straight to WRITE; anim_valid and anim_row are tied to 0.

Test Plan:
- Reset, then move_req with col=3, player=01, chk_done=1/chk_win=0 on the first CHK_WAIT cycle:
  - wr_en at cycle 2 with row=0, col=3, colour=01.
  - chk_start at cycle 3.
  - move_ack and turn_toggle at cycle 5; busy low at cycle 6.
- Six moves into col=0, then a 7th into col=0 → move_reject pulse; no wr_en; height unchanged. Then col=7 (>= COLS) → move_reject.
- Move with chk_win=1, player=10:
  - game_over=1, winner=10, no turn_toggle.
  - A later move_req → move_reject.
  - Reset clears game_over, winner and heights.
- Fill the board with chk_win=0 (42 moves):
  - 42nd move gives draw=1, game_over=1, winner=00, no move_ack.
- Hold chk_done=0 for 20 cycles, pulse move_req meanwhile:
  - stays in CHK_WAIT with busy=1; the extra request is dropped.
  - Reset mid-wait → IDLE, all outputs 0.
- With C4_DROP_ANIM_EN, DROP_CYCLES=4, col=2 holding 1 piece:
  - anim_row steps 5,4,3,2,1 at 4 cycles each.
  - wr_en with wr_row=1 follows 20 cycles after DROP entry.
